alu_sequencer: RTL and testbench

Command-side front end for the team's 8-bit combinational ALU (opcodes 0–10, 16-bit result). Accepts operation commands over a valid/ready interface, buffers them in a small FIFO, and drives the ALU operand/select inputs from registers. Samples the ALU result and returns it over a valid/ready response interface. Adds divide/modulo-by-zero and illegal-opcode detection, plus a result accumulator that lets commands chain on the previous result.

---
 rtl/alu_sequencer.sv | 146 ++++++++++++++
 tb/tb_alu_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: command-side front end for the 8-bit combinational ALU.
// Commands are buffered in a small in-order FIFO. A three-state FSM
// (IDLE -> EXEC -> RESP) issues one command at a time to the ALU through
// registered operands, samples the ALU result and returns it over a
// valid/ready response port. Divide/modulo by zero and illegal opcodes are
// flagged. A 16-bit accumulator holds the last non-error result so that a
// command can chain on it.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   cmd_valid/cmd_ready                command handshake (ready = !full)
//   cmd_op, cmd_a, cmd_b, cmd_use_acc  command payload
//   alu_a, alu_b, alu_sel              registered ALU inputs
//   alu_out                            combinational ALU result
//   rsp_valid/rsp_ready                response handshake
//   rsp_data, rsp_op, rsp_err          response payload
//   acc                                last non-error result
//   busy                               work pending or in flight
module alu_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic        cmd_use_acc,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_sel,
    input  logic [15:0] alu_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [3:0]  rsp_op,
    output logic        rsp_err,
    output logic [15:0] acc,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    // Entry layout: {op[20:17], a[16:9], b[8:1], use_acc[0]}
    logic [20:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop;
    logic [20:0]   head;

    state_t state, state_nxt;

    logic illegal_op, div_zero;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = mem[rd_ptr];
    assign busy      = (state != IDLE) || !empty;

    assign illegal_op = (alu_sel > 4'd10);
    assign div_zero   = ((alu_sel == 4'd4) || (alu_sel == 4'd5)) && (alu_b == 8'd0);

    // Storage needs no reset: count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b, cmd_use_acc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                pop       = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_op    <= '0;
            rsp_err   <= 1'b0;
            acc       <= '0;
        end else begin
            if (pop) begin
                alu_sel <= head[20:17];
                alu_b   <= head[8:1];
                // acc was already updated by the previous EXEC, so chaining
                // sees the immediately preceding good result.
                alu_a   <= head[0] ? acc[7:0] : head[16:9];
            end
            if (state == EXEC) begin
                rsp_valid <= 1'b1;
                rsp_op    <= alu_sel;
                if (illegal_op) begin
                    rsp_data <= 16'h0000;
                    rsp_err  <= 1'b1;
                end else if (div_zero) begin
                    rsp_data <= 16'hFFFF;
                    rsp_err  <= 1'b1;
                end else begin
                    rsp_data <= alu_out;
                    rsp_err  <= 1'b0;
                    acc      <= alu_out;
                end
            end
            if (state == RESP && rsp_ready)
                rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [7:0]  cmd_a = '0, cmd_b = '0;
    logic        cmd_use_acc = 1'b0;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_sel;
    logic [15:0] alu_out;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_op;
    logic        rsp_err;
    logic [15:0] acc;
    logic        busy;

    alu_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_err(rsp_err),
        .acc(acc), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the team's combinational ALU. Garbage on div-by-zero and
    // illegal opcodes so that the sequencer must ignore alu_out there.
    always_comb begin
        logic [15:0] x, y;
        x = {8'h00, alu_a};
        y = {8'h00, alu_b};
        alu_out = 16'h0000;
        case (alu_sel)
            4'd0:  alu_out = x + y;
            4'd1:  alu_out = x + 16'd1;
            4'd2:  alu_out = x - y;
            4'd3:  alu_out = x * y;
            4'd4:  alu_out = (alu_b == 0) ? 16'hBEEF : x / y;
            4'd5:  alu_out = (alu_b == 0) ? 16'hBEEF : x % y;
            4'd6:  alu_out = x & y;
            4'd7:  alu_out = x | y;
            4'd8:  alu_out = ~(x & y);
            4'd9:  alu_out = ~(x | y);
            4'd10: alu_out = x ^ y;
            default: alu_out = 16'hDEAD;
        endcase
    end

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       ua;
    } cmd_t;

    cmd_t        expq[$];
    cmd_t        cur;
    logic [15:0] macc = 16'h0;
    bit          rand_rdy = 1'b0;
    int          errs = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: what each command must return, given the accumulator
    // as left by all earlier commands.
    function automatic void model(input cmd_t c, input logic [15:0] acc_in,
                                  output logic [15:0] d, output logic e,
                                  output logic [15:0] acc_out);
        int x, y;
        x = c.ua ? int'(acc_in[7:0]) : int'(c.a);
        y = int'(c.b);
        e = 1'b0;
        d = 16'h0;
        case (c.op)
            4'd0:  d = 16'(x + y);
            4'd1:  d = 16'(x + 1);
            4'd2:  d = 16'((x - y + 65536) % 65536);
            4'd3:  d = 16'(x * y);
            4'd4:  if (y == 0) begin e = 1'b1; d = 16'hFFFF; end else d = 16'(x / y);
            4'd5:  if (y == 0) begin e = 1'b1; d = 16'hFFFF; end else d = 16'(x % y);
            4'd6:  d = 16'(x & y);
            4'd7:  d = 16'(x | y);
            4'd8:  d = 16'(65280 + (255 - (x & y)));
            4'd9:  d = 16'(65280 + (255 - (x | y)));
            4'd10: d = 16'(x ^ y);
            default: begin e = 1'b1; d = 16'h0; end
        endcase
        acc_out = e ? acc_in : d;
    endfunction

    // Called at the falling edge: score any visible response (held ones too)
    // and note whether the command on the bus is being accepted.
    task automatic sample(output bit took);
        logic [15:0] d, na;
        logic        e;
        if (rsp_valid) begin
            if (expq.size() == 0) begin
                chk("stray_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                model(expq[0], macc, d, e, na);
                chk("rsp_data", 32'(rsp_data), 32'(d));
                chk("rsp_err",  32'(rsp_err),  32'(e));
                chk("rsp_op",   32'(rsp_op),   32'(expq[0].op));
                chk("rsp_acc",  32'(acc),      32'(na));
                if (rsp_ready) begin
                    void'(expq.pop_front());
                    macc = na;
                end
            end
        end
        took = cmd_valid && cmd_ready;
    endtask

    task automatic post(input bit took);
        if (took) expq.push_back(cur);
        if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic tick();
        bit t;
        @(negedge clk);
        sample(t);
        @(posedge clk);
        #1;
        post(t);
    endtask

    task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic ua);
        bit t;
        t = 1'b0;
        cur = '{op: op, a: a, b: b, ua: ua};
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
        cmd_valid = 1'b1;
        for (int i = 0; i < 60 && !t; i++) begin
            @(negedge clk);
            sample(t);
            @(posedge clk);
            #1;
            post(t);
        end
        if (!t) chk("push_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (expq.size() != 0 || busy); i++) tick();
        chk("drain_done", 32'(expq.size() == 0 && !busy), 32'd1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
        chk({tag, "_rsp_op"},    32'(rsp_op),    32'd0);
        chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        chk({tag, "_acc"},       32'(acc),       32'd0);
        chk({tag, "_alu"},       {12'd0, alu_sel, alu_a, alu_b}, 32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    initial begin
        bit t;
        // Power-on reset
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        rst_n = 1'b1;

        // Single add with latency: accept at N, ALU inputs after N+1,
        // rsp_valid after N+2.
        push(4'd0, 8'd200, 8'd100, 1'b0);
        @(negedge clk);
        chk("lat_n0_vld", 32'(rsp_valid), 32'd0);
        chk("lat_n0_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_n1_alu", {12'd0, alu_sel, alu_a, alu_b}, {12'd0, 4'd0, 8'd200, 8'd100});
        chk("lat_n1_vld", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_n2_vld", 32'(rsp_valid), 32'd1);
        chk("add_300", 32'(rsp_data), 32'd300);
        sample(t);
        @(posedge clk); #1;
        post(t);
        drain();
        chk("add_acc", 32'(acc), 32'd300);

        // Chaining
        push(4'd3, 8'd12, 8'd12, 1'b0);
        push(4'd0, 8'd0, 8'd1, 1'b1);
        drain();
        chk("chain_acc", 32'(acc), 32'd145);

        // Errors
        push(4'd4, 8'd50, 8'd0, 1'b0);
        push(4'd13, 8'd1, 8'd2, 1'b0);
        push(4'd5, 8'd50, 8'd7, 1'b0);
        drain();
        chk("err_acc", 32'(acc), 32'd1);

        // Backpressure: 5 accepted (4 queued + 1 in flight), 6th refused.
        rsp_ready = 1'b0;
        push(4'd0, 8'd0, 8'd9, 1'b1);
        push(4'd2, 8'd3, 8'd5, 1'b0);
        push(4'd10, 8'hA5, 8'h3C, 1'b0);
        push(4'd8, 8'hF0, 8'h3C, 1'b0);
        push(4'd9, 8'h0F, 8'h30, 1'b0);
        cur = '{op: 4'd7, a: 8'h81, b: 8'h18, ua: 1'b0};
        cmd_op = cur.op; cmd_a = cur.a; cmd_b = cur.b; cmd_use_acc = cur.ua;
        cmd_valid = 1'b1;
        repeat (3) tick();
        chk("bp_full", 32'(cmd_ready), 32'd0);
        chk("bp_hold_vld", 32'(rsp_valid), 32'd1);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        push(4'd7, 8'h81, 8'h18, 1'b0);
        drain();

        // Simultaneous push/pop with 2 queued; afterwards exactly 2 more
        // fit before full.
        rsp_ready = 1'b0;
        push(4'd0, 8'd1, 8'd1, 1'b0);
        push(4'd0, 8'd2, 8'd2, 1'b0);
        push(4'd0, 8'd3, 8'd3, 1'b0);
        tick();
        rsp_ready = 1'b1;
        tick();
        push(4'd2, 8'd3, 8'd5, 1'b0);
        rsp_ready = 1'b0;
        push(4'd6, 8'hCC, 8'hAA, 1'b0);
        push(4'd1, 8'd254, 8'd77, 1'b0);
        tick();
        chk("pp_full", 32'(cmd_ready), 32'd0);
        rsp_ready = 1'b1;
        drain();

        // Reset mid-operation: one in RESP, three queued.
        rsp_ready = 1'b0;
        push(4'd0, 8'd10, 8'd10, 1'b0);
        push(4'd0, 8'd11, 8'd11, 1'b0);
        push(4'd0, 8'd12, 8'd12, 1'b0);
        push(4'd0, 8'd13, 8'd13, 1'b0);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check_reset("mid");
        expq.delete();
        macc = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (10) tick();
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Randomized traffic with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 80; i++) begin
            logic [3:0] op;
            logic [7:0] b;
            op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(11, 15))
                                             : 4'($urandom_range(0, 10));
            b  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            push(op, 8'($urandom_range(0, 255)), b, 1'($urandom_range(0, 1)));
        end
        drain();
        rand_rdy = 1'b0;
        rsp_ready = 1'b1;
        drain();
        chk("final_acc", 32'(acc), 32'(macc));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
